pipe_arbiter: RTL and testbench

PIPE_ARBITER -- requirements
Module: pipe_arbiter

---
 rtl/pipe_arbiter.sv | 125 ++++++++++++
 tb/tb_pipe_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipe_arbiter.sv
// rtl/pipe_arbiter.sv - round-robin arbiter feeding a fixed-latency shared delay pipeline
// Grants at most one requester per cycle; each payload returns to its owner exactly Depth cycles later.
module pipe_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int Depth     = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                issue_en_i,
    input  logic                                flush_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_data_i,
    output logic [NumReq-1:0]                   req_ready_o,
    output logic [NumReq-1:0]                   resp_valid_o,
    output logic [DataWidth-1:0]                resp_data_o,
    output logic [$clog2(Depth+1)-1:0]          inflight_o,
    output logic                                busy_o
);

    localparam int TagW = $clog2(NumReq);
    localparam int CntW = $clog2(Depth+1);

    logic [TagW-1:0]      ptr_q, ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [Depth-1:0]     valid_q, valid_d;
    logic [TagW-1:0]      tag_q  [Depth];
    logic [DataWidth-1:0] data_q [Depth];

    logic                 found;
    logic                 grant_any;
    logic [TagW-1:0]      grant_idx;
    logic [TagW-1:0]      cand_idx;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand_idx = TagW'((int'(ptr_q) + k) % NumReq);
            if (!found && req_valid_i[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant_any = found && issue_en_i && !flush_i && !rst_i;

    always_comb begin
        req_ready_o = '0;
        if (grant_any) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == TagW'(NumReq-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        valid_d    = '0;
        valid_d[0] = grant_any;
        for (int i = 1; i < Depth; i++) begin
            valid_d[i] = valid_q[i-1];
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    // Entering and leaving in the same cycle leaves the occupancy unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (grant_any && !valid_q[Depth-1]) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!grant_any && valid_q[Depth-1]) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Payload and tag carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        tag_q[0]  <= grant_idx;
        data_q[0] <= req_data_i[grant_idx];
        for (int i = 1; i < Depth; i++) begin
            tag_q[i]  <= tag_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    always_comb begin
        resp_valid_o = '0;
        if (valid_q[Depth-1]) begin
            resp_valid_o[tag_q[Depth-1]] = 1'b1;
        end
    end

    assign resp_data_o = data_q[Depth-1];
    assign inflight_o  = cnt_q;
    assign busy_o      = |cnt_q;

    a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(req_ready_o));
    a_ready_needs_valid: assert property (@(posedge clk_i) (req_ready_o & ~req_valid_i) == '0);
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) int'(cnt_q) <= Depth);

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb/tb_pipe_arbiter.sv - directed vector table plus reset and saturation sequences for pipe_arbiter
module tb_pipe_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             issue_en_i;
    logic             flush_i;
    logic [3:0]       req_valid_i;
    logic [3:0][31:0] req_data_i;
    logic [3:0]       req_ready_o;
    logic [3:0]       resp_valid_o;
    logic [31:0]      resp_data_o;
    logic [1:0]       inflight_o;
    logic             busy_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        fl;
        logic [3:0]  vld;
        logic [3:0]  rdy;
        logic [3:0]  rvld;
        logic [31:0] rdata;
        logic [1:0]  infl;
    } vec_t;

    vec_t tbl[$];

    pipe_arbiter #(.NumReq(4), .DataWidth(32), .Depth(3)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .issue_en_i   (issue_en_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .inflight_o   (inflight_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic f, input logic [3:0] v,
                       input logic [3:0] rd, input logic [3:0] rv, input logic [31:0] d,
                       input logic [1:0] n);
        vec_t x;
        x.rst = r; x.en = e; x.fl = f; x.vld = v;
        x.rdy = rd; x.rvld = rv; x.rdata = d; x.infl = n;
        tbl.push_back(x);
    endtask

    task automatic set_data(input int step);
        for (int i = 0; i < 4; i++) req_data_i[i] = 32'(step * 256 + i);
    endtask

    initial begin
        // step: rst en fl vld  | ready  resp  data  inflight   (payload = step*0x100 + requester)
        add(0,1,0,4'b0100, 4'b0100,4'b0000,32'h0,   2'd0); // s0 single request, req 2
        add(0,1,0,4'b0000, 4'b0000,4'b0000,32'h0,   2'd1);
        add(0,1,0,4'b0000, 4'b0000,4'b0000,32'h0,   2'd1);
        add(0,1,0,4'b0000, 4'b0000,4'b0100,32'h002, 2'd1); // s3 exact latency 3
        add(0,1,0,4'b0010, 4'b0010,4'b0000,32'h0,   2'd0); // s4 ptr 3, only req 1 -> wrap
        add(0,1,0,4'b0110, 4'b0100,4'b0000,32'h0,   2'd1); // s5 ptr 2
        add(0,1,0,4'b0110, 4'b0010,4'b0000,32'h0,   2'd2); // s6 ptr 3 -> wraps to 1
        add(0,1,0,4'b0000, 4'b0000,4'b0010,32'h401, 2'd3);
        add(0,1,0,4'b0000, 4'b0000,4'b0100,32'h502, 2'd2);
        add(0,1,0,4'b0000, 4'b0000,4'b0010,32'h601, 2'd1);
        add(0,0,0,4'b1111, 4'b0000,4'b0000,32'h0,   2'd0); // s10 issue disabled
        add(0,1,0,4'b1111, 4'b0100,4'b0000,32'h0,   2'd0); // s11 pointer held at 2
        add(0,1,0,4'b1111, 4'b1000,4'b0000,32'h0,   2'd1);
        add(0,1,0,4'b1111, 4'b0001,4'b0000,32'h0,   2'd2);
        add(0,1,0,4'b1111, 4'b0010,4'b0100,32'hB02, 2'd3); // s14 grant and retire together
        add(0,0,0,4'b1111, 4'b0000,4'b1000,32'hC03, 2'd3); // s15 drain while disabled
        add(0,0,0,4'b1111, 4'b0000,4'b0001,32'hD00, 2'd2);
        add(0,1,0,4'b1111, 4'b0100,4'b0010,32'hE01, 2'd1);
        add(0,1,0,4'b1111, 4'b1000,4'b0000,32'h0,   2'd1);
        add(0,1,0,4'b1111, 4'b0001,4'b0000,32'h0,   2'd2);
        add(0,1,1,4'b1111, 4'b0000,4'b0100,32'h1102,2'd3); // s20 flush: pre-flush response still shown
        add(0,1,0,4'b0000, 4'b0000,4'b0000,32'h0,   2'd0);
        add(0,1,0,4'b0000, 4'b0000,4'b0000,32'h0,   2'd0);
        add(0,1,0,4'b0000, 4'b0000,4'b0000,32'h0,   2'd0);
        add(0,1,0,4'b1111, 4'b0010,4'b0000,32'h0,   2'd0); // s24 pointer 1 survives flush
        add(0,1,0,4'b1111, 4'b0100,4'b0000,32'h0,   2'd1);
        add(1,1,0,4'b1111, 4'b0000,4'b0000,32'h0,   2'd2); // s26 reset with 2 in flight
        add(0,1,0,4'b1111, 4'b0001,4'b0000,32'h0,   2'd0); // s27 first grant after reset is 0
        add(0,1,0,4'b0000, 4'b0000,4'b0000,32'h0,   2'd1);
        add(0,1,0,4'b0000, 4'b0000,4'b0000,32'h0,   2'd1);
        add(0,1,0,4'b0000, 4'b0000,4'b0001,32'h1B00,2'd1);
        add(0,1,0,4'b0000, 4'b0000,4'b0000,32'h0,   2'd0);

        rst_i = 1'b1; issue_en_i = 1'b1; flush_i = 1'b0; req_valid_i = 4'b1111; set_data(0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #1;
        chk("reset_ready",    32'(req_ready_o),  32'h0);
        chk("reset_resp",     32'(resp_valid_o), 32'h0);
        chk("reset_inflight", 32'(inflight_o),   32'h0);
        chk("reset_busy",     32'(busy_o),       32'h0);

        foreach (tbl[k]) begin
            if (k != 0) @(negedge clk_i);
            rst_i = tbl[k].rst; issue_en_i = tbl[k].en; flush_i = tbl[k].fl;
            req_valid_i = tbl[k].vld; set_data(k);
            #1;
            chk($sformatf("s%0d_ready", k),    32'(req_ready_o),  32'(tbl[k].rdy));
            chk($sformatf("s%0d_resp", k),     32'(resp_valid_o), 32'(tbl[k].rvld));
            chk($sformatf("s%0d_inflight", k), 32'(inflight_o),   32'(tbl[k].infl));
            chk($sformatf("s%0d_busy", k),     32'(busy_o),       32'(tbl[k].infl != 0));
            if (tbl[k].rvld != 0) chk($sformatf("s%0d_data", k), resp_data_o, tbl[k].rdata);
        end

        // Continuous all-valid traffic from reset: grants cycle 0..3, occupancy saturates at 3.
        @(negedge clk_i);
        rst_i = 1'b1; flush_i = 1'b0; issue_en_i = 1'b1; req_valid_i = 4'b1111;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk_i);
            set_data(100 + c);
            #1;
            chk($sformatf("rr%0d_ready", c),    32'(req_ready_o), 32'(4'b0001 << (c % 4)));
            chk($sformatf("rr%0d_inflight", c), 32'(inflight_o),  32'((c < 3) ? c : 3));
            if (c >= 3) begin
                chk($sformatf("rr%0d_resp", c), 32'(resp_valid_o), 32'(4'b0001 << ((c - 3) % 4)));
                chk($sformatf("rr%0d_data", c), resp_data_o, 32'((100 + c - 3) * 256 + (c - 3) % 4));
            end else begin
                chk($sformatf("rr%0d_resp", c), 32'(resp_valid_o), 32'h0);
            end
        end

        @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
